// File: rtl/util_io_loop_monitor.sv
// Per-channel pass/error accumulator for the IO loopback tester, with sticky flags and a read port.
// Optional per-channel stale timers are compiled in with UTIL_IO_LOOP_MONITOR_TIMEOUT_EN.
module util_io_loop_monitor #(
    parameter int IO_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 clr,
    input  logic                 freeze_on_err,
    input  logic [31:0]          timeout_limit,
    input  logic [IO_WIDTH-1:0]  io_state,
    input  logic [IO_WIDTH-1:0]  io_state_valid,
    input  logic                 rd_req,
    input  logic [7:0]           rd_sel,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_pass_cnt,
    output logic [CNT_WIDTH-1:0] rd_err_cnt,
    output logic [IO_WIDTH-1:0]  err_mask,
    output logic                 err_any,
    output logic [IO_WIDTH-1:0]  stale_mask,
    output logic [7:0]           first_err_ch,
    output logic                 first_err_valid,
    output logic                 halted
);

    localparam int IDX_W = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e state_q;
    logic   halted_q;

    logic                 run_s;
    logic [IO_WIDTH-1:0]  pass_evt_s;
    logic [IO_WIDTH-1:0]  err_evt_s;

    logic [CNT_WIDTH-1:0] pass_cnt_q [IO_WIDTH];
    logic [CNT_WIDTH-1:0] pass_cnt_d [IO_WIDTH];
    logic [CNT_WIDTH-1:0] err_cnt_q  [IO_WIDTH];
    logic [CNT_WIDTH-1:0] err_cnt_d  [IO_WIDTH];
    logic [IO_WIDTH-1:0]  err_mask_q;
    logic [IO_WIDTH-1:0]  err_mask_d;
    logic                 err_any_q;
    logic [7:0]           first_err_ch_q;
    logic [7:0]           first_err_ch_d;
    logic                 first_err_valid_q;
    logic                 first_err_valid_d;

    logic                 rd_in_range_s;
    logic [IDX_W-1:0]     rd_idx_s;
    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_pass_q;
    logic [CNT_WIDTH-1:0] rd_pass_d;
    logic [CNT_WIDTH-1:0] rd_err_q;
    logic [CNT_WIDTH-1:0] rd_err_d;

    // Lowest set index wins when several channels fail together.
    function automatic logic [7:0] lowest_set(input logic [IO_WIDTH-1:0] vec);
        logic [7:0] idx;
        idx = 8'd0;
        for (int i = IO_WIDTH - 1; i >= 0; i--) begin
            idx = vec[i] ? 8'(i) : idx;
        end
        return idx;
    endfunction

    assign run_s      = (state_q == ST_RUN);
    assign pass_evt_s = io_state_valid & ~io_state & {IO_WIDTH{run_s}};
    assign err_evt_s  = io_state_valid &  io_state & {IO_WIDTH{run_s}};

    // Run-control FSM; halted is registered from the state, so it lags the state by one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
        end else if (clr) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_q == ST_HALT);
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (freeze_on_err && (|err_evt_s)) begin
                        state_q <= ST_HALT;
                    end else if (!enable) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Next-state for counters, sticky error flags and first-failure capture.
    always_comb begin
        pass_cnt_d        = pass_cnt_q;
        err_cnt_d         = err_cnt_q;
        err_mask_d        = err_mask_q;
        first_err_ch_d    = first_err_ch_q;
        first_err_valid_d = first_err_valid_q;
        if (clr) begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                pass_cnt_d[i] = {CNT_WIDTH{1'b0}};
                err_cnt_d[i]  = {CNT_WIDTH{1'b0}};
            end
            err_mask_d        = {IO_WIDTH{1'b0}};
            first_err_ch_d    = 8'd0;
            first_err_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                if (pass_evt_s[i] && (pass_cnt_q[i] != CNT_MAX)) begin
                    pass_cnt_d[i] = pass_cnt_q[i] + CNT_ONE;
                end else begin
                    pass_cnt_d[i] = pass_cnt_q[i];
                end
                if (err_evt_s[i] && (err_cnt_q[i] != CNT_MAX)) begin
                    err_cnt_d[i] = err_cnt_q[i] + CNT_ONE;
                end else begin
                    err_cnt_d[i] = err_cnt_q[i];
                end
            end
            err_mask_d = err_mask_q | err_evt_s;
            if (!first_err_valid_q && (|err_evt_s)) begin
                first_err_ch_d    = lowest_set(err_evt_s);
                first_err_valid_d = 1'b1;
            end else begin
                first_err_ch_d    = first_err_ch_q;
                first_err_valid_d = first_err_valid_q;
            end
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                pass_cnt_q[i] <= {CNT_WIDTH{1'b0}};
                err_cnt_q[i]  <= {CNT_WIDTH{1'b0}};
            end
            err_mask_q        <= {IO_WIDTH{1'b0}};
            first_err_ch_q    <= 8'd0;
            first_err_valid_q <= 1'b0;
        end else begin
            pass_cnt_q        <= pass_cnt_d;
            err_cnt_q         <= err_cnt_d;
            err_mask_q        <= err_mask_d;
            first_err_ch_q    <= first_err_ch_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    // err_any is the registered OR of the already-registered mask.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_any_q <= 1'b0;
        end else if (clr) begin
            err_any_q <= 1'b0;
        end else begin
            err_any_q <= |err_mask_q;
        end
    end

    assign rd_in_range_s = ({1'b0, rd_sel} < 9'(IO_WIDTH));
    assign rd_idx_s      = rd_sel[IDX_W-1:0];

    // Read mux samples the pre-update counters; data holds between reads.
    always_comb begin
        rd_pass_d = rd_pass_q;
        rd_err_d  = rd_err_q;
        if (rd_req && rd_in_range_s) begin
            rd_pass_d = pass_cnt_q[rd_idx_s];
            rd_err_d  = err_cnt_q[rd_idx_s];
        end else if (rd_req) begin
            rd_pass_d = {CNT_WIDTH{1'b0}};
            rd_err_d  = {CNT_WIDTH{1'b0}};
        end else begin
            rd_pass_d = rd_pass_q;
            rd_err_d  = rd_err_q;
        end
    end

    // Read port registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_pass_q  <= {CNT_WIDTH{1'b0}};
            rd_err_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            rd_valid_q <= rd_req;
            rd_pass_q  <= rd_pass_d;
            rd_err_q   <= rd_err_d;
        end
    end

`ifdef UTIL_IO_LOOP_MONITOR_TIMEOUT_EN
    logic [31:0]         timer_q [IO_WIDTH];
    logic [31:0]         timer_d [IO_WIDTH];
    logic [IO_WIDTH-1:0] stale_q;
    logic [IO_WIDTH-1:0] stale_d;

    // Idle timers advance only in RUN and park once they hit the limit.
    always_comb begin
        timer_d = timer_q;
        stale_d = stale_q;
        if (clr) begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                timer_d[i] = 32'd0;
            end
            stale_d = {IO_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                if (io_state_valid[i]) begin
                    timer_d[i] = 32'd0;
                end else if (run_s && (timeout_limit != 32'd0) && (timer_q[i] == timeout_limit)) begin
                    timer_d[i] = timer_q[i];
                    stale_d[i] = 1'b1;
                end else if (run_s) begin
                    timer_d[i] = timer_q[i] + 32'd1;
                end else begin
                    timer_d[i] = timer_q[i];
                end
            end
        end
    end

    // Timer and stale flag registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                timer_q[i] <= 32'd0;
            end
            stale_q <= {IO_WIDTH{1'b0}};
        end else begin
            timer_q <= timer_d;
            stale_q <= stale_d;
        end
    end

    assign stale_mask = stale_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^timeout_limit;
    assign stale_mask       = {IO_WIDTH{1'b0}};
`endif

    assign rd_valid        = rd_valid_q;
    assign rd_pass_cnt     = rd_pass_q;
    assign rd_err_cnt      = rd_err_q;
    assign err_mask        = err_mask_q;
    assign err_any         = err_any_q;
    assign first_err_ch    = first_err_ch_q;
    assign first_err_valid = first_err_valid_q;
    assign halted          = halted_q;

endmodule
